// File: rtl/stopwatch_tick_ctrl.sv
// stopwatch_tick_ctrl: debounced start/clear buttons gating a prescaled count-enable tick for the BCD counter
module stopwatch_tick_db #(
    parameter int DB_CYCLES = 1000000,
    parameter int DB_W      = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n,
    output logic press
);
    logic            s1;
    logic            s2;
    logic            deb;
    logic            deb_d;
    logic [DB_W-1:0] cnt;
    // synchronise the raw level, accept a change only after DB_CYCLES steady mismatching samples, keep last level for edge detect
    always_ff @(posedge clk) begin
        if (rst) begin
            s1    <= 1'b1;
            s2    <= 1'b1;
            deb   <= 1'b1;
            deb_d <= 1'b1;
            cnt   <= '0;
        end else begin
            s1    <= btn_n;
            s2    <= s1;
            deb_d <= deb;
            if (s2 == deb) begin
                cnt <= '0;
            end else if (cnt == DB_W'(DB_CYCLES - 1)) begin
                deb <= s2;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
    assign press = deb_d & ~deb;
endmodule

module stopwatch_tick_ctrl #(
    parameter int DIV_W     = 24,
    parameter int DB_CYCLES = 1000000,
    parameter int DB_W      = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_start_n,
    input  logic       btn_clear_n,
    output logic       tick,
    output logic       clr,
    output logic       running,
    output logic [1:0] state
);
    typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, PAUSE = 2'b10} state_t;
    state_t           st;
    state_t           nxt;
    logic [DIV_W-1:0] presc;
    logic             start_ev;
    logic             clear_ev;
    stopwatch_tick_db #(.DB_CYCLES(DB_CYCLES), .DB_W(DB_W)) u_db_start (
        .clk   (clk),
        .rst   (rst),
        .btn_n (btn_start_n),
        .press (start_ev)
    );
    stopwatch_tick_db #(.DB_CYCLES(DB_CYCLES), .DB_W(DB_W)) u_db_clear (
        .clk   (clk),
        .rst   (rst),
        .btn_n (btn_clear_n),
        .press (clear_ev)
    );
    // clear overrides start; start toggles between RUN and PAUSE, leaving IDLE into RUN
    always_comb begin
        nxt = clear_ev ? IDLE : !start_ev ? st : (st == RUN) ? PAUSE : RUN;
    end
    // state, prescaler and registered pulses; a wrap on the edge that leaves RUN produces no tick
    always_ff @(posedge clk) begin
        if (rst) begin
            st    <= IDLE;
            presc <= '0;
            tick  <= 1'b0;
            clr   <= 1'b0;
        end else begin
            st    <= nxt;
            clr   <= clear_ev;
            presc <= (st == RUN) ? presc + 1'b1 : (st == PAUSE) ? presc : '0;
            tick  <= (st == RUN) && (presc == '1) && (nxt == RUN);
        end
    end
    assign state   = st;
    assign running = (st == RUN);
endmodule

// File: tb/tb_stopwatch_tick_ctrl.sv
// tb_stopwatch_tick_ctrl: directed and randomized button stimulus checked against a behavioural stopwatch model
module tb_stopwatch_tick_ctrl;
    localparam int DIV_W     = 3;
    localparam int DB_CYCLES = 4;
    localparam int DB_W      = 3;
    localparam int PERIOD    = 1 << DIV_W;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_start_n = 1'b1;
    logic       btn_clear_n = 1'b1;
    logic       tick;
    logic       clr;
    logic       running;
    logic [1:0] state;

    int vectors = 0;
    int miscompares = 0;

    // model: state as 0 IDLE / 1 RUN / 2 PAUSE, accumulated run time modulo the tick period
    int m_state, m_run, m_tick, m_clr;
    // per button (0 start, 1 clear): raw samples one and two edges old, accepted level, mismatch streak, pending press
    int h0[2], h1[2], deb[2], streak[2], pend[2];

    stopwatch_tick_ctrl #(.DIV_W(DIV_W), .DB_CYCLES(DB_CYCLES), .DB_W(DB_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_start_n (btn_start_n),
        .btn_clear_n (btn_clear_n),
        .tick        (tick),
        .clr         (clr),
        .running     (running),
        .state       (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // advance the model by one clock edge given the inputs present at that edge
    task automatic model(input logic r, input logic bs, input logic bc);
        int b_in[2];
        int ev[2];
        int prev;
        int sync;
        b_in[0] = bs;
        b_in[1] = bc;
        if (r) begin
            m_state = 0; m_run = 0; m_tick = 0; m_clr = 0;
            for (int b = 0; b < 2; b++) begin
                h0[b] = 1; h1[b] = 1; deb[b] = 1; streak[b] = 0; pend[b] = 0;
            end
            return;
        end
        ev = pend;
        prev = m_state;
        if (ev[1] != 0) m_state = 0;
        else if (ev[0] != 0) m_state = (m_state == 1) ? 2 : 1;
        m_clr = ev[1];
        m_tick = 0;
        if (prev == 1) begin
            m_run = (m_run + 1) % PERIOD;
            m_tick = (m_run == 0 && m_state == 1) ? 1 : 0;
        end else if (prev == 0) begin
            m_run = 0;
        end
        for (int b = 0; b < 2; b++) begin
            sync = h1[b];
            h1[b] = h0[b];
            h0[b] = b_in[b];
            pend[b] = 0;
            if (sync == deb[b]) begin
                streak[b] = 0;
            end else begin
                streak[b]++;
                if (streak[b] == DB_CYCLES) begin
                    deb[b] = sync;
                    streak[b] = 0;
                    pend[b] = (sync == 0) ? 1 : 0;
                end
            end
        end
    endtask

    task automatic step(input logic r, input logic bs, input logic bc);
        @(negedge clk);
        rst = r;
        btn_start_n = bs;
        btn_clear_n = bc;
        model(r, bs, bc);
        @(posedge clk);
        #1;
        chk("state", int'(state), m_state);
        chk("running", int'(running), (m_state == 1) ? 1 : 0);
        chk("tick", int'(tick), m_tick);
        chk("clr", int'(clr), m_clr);
        chk("tick_clr_excl", int'(tick & clr), 0);
    endtask

    task automatic hold(input logic r, input logic bs, input logic bc, input int n);
        for (int i = 0; i < n; i++) step(r, bs, bc);
    endtask

    initial begin
        int   ls, lc;
        logic rbs, rbc, rr;
        model(1'b1, 1'b1, 1'b1);
        // reset state
        hold(1, 1, 1, 2);
        chk("reset_state", int'(state), 0);
        chk("reset_tick", int'(tick), 0);
        chk("reset_clr", int'(clr), 0);
        chk("reset_running", int'(running), 0);
        hold(0, 1, 1, 3);
        // glitch shorter than the debounce window
        hold(0, 0, 1, 3);
        hold(0, 1, 1, 12);
        chk("glitch_state", int'(state), 0);
        // start press: transition on edge 6 counted from the first low sample, first tick a full period later
        hold(0, 0, 1, 6);
        chk("start_pre", int'(state), 0);
        step(0, 0, 1);
        chk("start_edge6", int'(state), 1);
        chk("start_running", int'(running), 1);
        for (int i = 1; i <= PERIOD; i++) begin
            step(0, 0, 1);
            chk("first_tick", int'(tick), (i == PERIOD) ? 1 : 0);
        end
        hold(0, 0, 1, 5);
        chk("one_transition", int'(state), 1);
        hold(0, 1, 1, 10);
        // reset in the middle of RUN
        hold(1, 1, 1, 2);
        chk("rst_state", int'(state), 0);
        chk("rst_tick", int'(tick), 0);
        chk("rst_clr", int'(clr), 0);
        chk("rst_running", int'(running), 0);
        for (int i = 0; i < PERIOD; i++) begin
            step(0, 1, 1);
            chk("rst_no_tick", int'(tick), 0);
        end
        // pause after 13 RUN edges (5 into a period), resume finishes the remaining 3
        hold(0, 0, 1, 7);
        chk("run_again", int'(state), 1);
        hold(0, 1, 1, 6);
        hold(0, 0, 1, 7);
        chk("pause_state", int'(state), 2);
        for (int i = 0; i < 6; i++) begin
            step(0, 1, 1);
            chk("pause_no_tick", int'(tick), 0);
        end
        hold(0, 0, 1, 7);
        chk("resume_state", int'(state), 1);
        for (int i = 1; i <= 3; i++) begin
            step(0, 0, 1);
            chk("resume_tick", int'(tick), (i == 3) ? 1 : 0);
        end
        hold(0, 0, 1, 3);
        hold(0, 1, 1, 8);
        // clear from RUN
        hold(0, 1, 0, 6);
        chk("clear_pre", int'(state), 1);
        step(0, 1, 0);
        chk("clear_state", int'(state), 0);
        chk("clear_pulse", int'(clr), 1);
        step(0, 1, 0);
        chk("clear_once", int'(clr), 0);
        hold(0, 1, 0, 3);
        for (int i = 0; i < 10; i++) begin
            step(0, 1, 1);
            chk("clear_no_tick", int'(tick), 0);
        end
        // clear while already IDLE
        hold(0, 1, 0, 7);
        chk("clear_idle_pulse", int'(clr), 1);
        chk("clear_idle_state", int'(state), 0);
        step(0, 1, 0);
        chk("clear_idle_once", int'(clr), 0);
        hold(0, 1, 1, 8);
        // simultaneous start and clear while PAUSE
        hold(0, 0, 1, 7);
        hold(0, 1, 1, 6);
        hold(0, 0, 1, 7);
        chk("simul_pause", int'(state), 2);
        hold(0, 1, 1, 6);
        hold(0, 0, 0, 7);
        chk("simul_state", int'(state), 0);
        chk("simul_clr", int'(clr), 1);
        for (int i = 0; i < 12; i++) begin
            step(0, 1, 1);
            chk("simul_no_run", int'(state), 0);
        end
        // randomized button activity with occasional resets
        rbs = 1'b1; rbc = 1'b1; ls = 4; lc = 9;
        for (int i = 0; i < 4000; i++) begin
            if (ls <= 0) begin
                rbs = ~rbs;
                ls = $urandom_range(1, 20);
            end
            if (lc <= 0) begin
                rbc = ~rbc;
                lc = (rbc == 1'b0) ? $urandom_range(1, 12) : $urandom_range(10, 60);
            end
            rr = ($urandom_range(0, 299) == 0);
            step(rr, rbs, rbc);
            ls--;
            lc--;
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
